uart_nibble_bridge: RTL and testbench
=====================================

UART_NIBBLE_BRIDGE -- requirements
Module: uart_nibble_bridge

Interface
REQ-001 The block SHALL have a single clock domain and an asynchronous, active-low reset.
REQ-002 Parameter DEPTH SHALL default to 4 and set the RX byte-FIFO depth; legal values are powers of two, 2..16.
REQ-003 clock  in  1  system clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 rx_valid  in  1  one-cycle strobe from the UART receiver: rx_byte holds a complete byte.
REQ-006 rx_byte  in  8  received byte; sampled only when rx_valid=1.
REQ-007 overrun  out  1  one-cycle pulse: a received byte was dropped.
REQ-008 nib_out_valid  out  1  nib_out holds a valid nibble.
REQ-009 nib_out  out  4  nibble toward the 4-bit bus.
REQ-010 nib_out_ready  in  1  consumer accepts nib_out this cycle.
REQ-011 nib_in_valid  in  1  nib_in holds a valid nibble.
REQ-012 nib_in  in  4  nibble from the 4-bit bus.
REQ-013 nib_in_ready  out  1  bridge accepts nib_in this cycle.
REQ-014 tx_valid  out  1  tx_byte holds a packed byte for the UART transmitter.
REQ-015 tx_byte  out  8  byte to transmit.
REQ-016 tx_ready  in  1  transmitter accepts tx_byte this cycle.

Function
REQ-017 The RX FIFO SHALL use a count register of width clog2(DEPTH)+1, with read/write pointers wrapping modulo DEPTH.
REQ-018 rx_valid=1 with FIFO not full SHALL write rx_byte at the write pointer on that edge.
REQ-019 rx_valid=1 with FIFO full (judged on pre-edge state, regardless of a same-cycle pop) SHALL drop the byte, leave the FIFO unchanged, and drive overrun=1 for exactly the next cycle.
REQ-020 The unpacker SHALL be a 2-state machine, LO and HI; nib_out_valid SHALL equal (count!=0), driven from registered state only.
REQ-021 nib_out SHALL be head[3:0] in LO and head[7:4] in HI, so the low nibble goes first.
REQ-022 A nibble transfer SHALL occur on nib_out_valid&nib_out_ready; LO SHALL go to HI, and HI SHALL go to LO and pop the head.
REQ-023 Latency: a byte written into an empty FIFO at edge N SHALL give nib_out_valid=1 in the cycle after edge N.
REQ-024 A simultaneous write and pop SHALL leave count unchanged and advance both pointers.
REQ-025 With nib_out_valid=0, nib_out_ready SHALL be ignored and the state SHALL not change.
REQ-026 The packer SHALL be a 3-state machine: EMPTY, HAVE_LO, FULL.
REQ-027 nib_in_ready SHALL be 1 in EMPTY and HAVE_LO, and 0 in FULL (no same-cycle bypass, even with tx_ready=1).
REQ-028 In EMPTY, an accepted nibble SHALL be stored as the low nibble and the state SHALL go to HAVE_LO.
REQ-029 In HAVE_LO, an accepted nibble SHALL be stored as the high nibble and the state SHALL go to FULL.
REQ-030 tx_valid SHALL be 1 exactly in FULL, and tx_byte SHALL be {hi,lo}, registered and stable while tx_valid=1.
REQ-031 In FULL, tx_ready=1 SHALL return the state to EMPTY on that edge; without tx_ready the state SHALL stay FULL indefinitely.
REQ-032 The RX and TX paths SHALL be fully independent; activity on one SHALL not stall the other.

Reset
REQ-033 reset_n=0 SHALL immediately force overrun=0, nib_out_valid=0, nib_out=0, nib_in_ready=0, tx_valid=0, tx_byte=0.
REQ-034 Reset SHALL empty the FIFO and zero both pointers; the unpacker SHALL go to LO and the packer to EMPTY.
REQ-035 Reset mid-operation SHALL discard partial bytes and all buffered bytes.
REQ-036 After reset_n rises, nib_in_ready SHALL be 1 from the first clock edge onward; FIFO contents need no reset.

Verification
REQ-037 RX basic: strobe 0xA5 with nib_out_ready=1 -> nib_out 0x5, then 0xA on consecutive cycles; then nib_out_valid=0.
REQ-038 RX overrun: DEPTH=4, strobe 0x11,0x22,0x33,0x44,0x55 with nib_out_ready=0 -> overrun pulses once after 0x55; drain yields 1,1,2,2,3,3,4,4.
REQ-039 RX backpressure: toggle nib_out_ready randomly over 20 bytes -> nibble stream is lo/hi of each byte in order, no loss or duplication.
REQ-040 TX pack: nibbles 0x3 then 0xC with tx_ready=0 -> tx_valid=1, tx_byte=0xC3, nib_in_ready=0 held until tx_ready=1, then EMPTY.
REQ-041 Reset mid-stream: assert reset_n=0 in HI and HAVE_LO -> all outputs 0 asynchronously; after release, 0x7E passes through cleanly on both paths.
REQ-042 Simultaneous: rx_valid on the same cycle as the final HI pop with FIFO full -> byte dropped, overrun=1, count=DEPTH-1.

Source files
------------

// File: rtl/uart_nibble_bridge.sv
// uart_nibble_bridge: UART byte stream <-> 4-bit nibble bus, low nibble first.
// RX bytes queue in a small FIFO and unpack to nibbles; TX nibbles pack into bytes.
module uart_nibble_bridge #(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       overrun,
   output logic       nib_out_valid,
   output logic [3:0] nib_out,
   input  logic       nib_out_ready,
   input  logic       nib_in_valid,
   input  logic [3:0] nib_in,
   output logic       nib_in_ready,
   output logic       tx_valid,
   output logic [7:0] tx_byte,
   input  logic       tx_ready
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {LO, HI} up_t;
   typedef enum logic [1:0] {EMPTY, HAVE_LO, FULL} pk_t;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0] cnt_q, cnt_d;
   up_t up_q, up_d;
   pk_t pk_q, pk_d;
   logic [7:0] byte_q, byte_d;
   logic ov_q, ov_d, live_q, live_d;
   logic full, wr, xfer, pop, acc;
   always_comb begin
      full = cnt_q == (AW+1)'(DEPTH);
      wr = rx_valid && !full;
      nib_out_valid = cnt_q != '0;
      xfer = nib_out_valid && nib_out_ready;
      pop = xfer && up_q == HI;
      wp_d = wp_q + AW'(wr);
      rp_d = rp_q + AW'(pop);
      cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
      up_d = xfer ? (up_q == LO ? HI : LO) : up_q;
      ov_d = rx_valid && full;
      nib_out = !nib_out_valid ? 4'h0 : up_q == HI ? mem[rp_q][7:4] : mem[rp_q][3:0];
      overrun = ov_q;
      // live_q holds nib_in_ready low until the first edge after reset release
      live_d = 1'b1;
      nib_in_ready = live_q && pk_q != FULL;
      acc = nib_in_valid && nib_in_ready;
      pk_d = pk_q == FULL ? (tx_ready ? EMPTY : FULL) : acc ? (pk_q == EMPTY ? HAVE_LO : FULL) : pk_q;
      byte_d = !acc ? byte_q : pk_q == EMPTY ? {byte_q[7:4], nib_in} : {nib_in, byte_q[3:0]};
      tx_valid = pk_q == FULL;
      tx_byte = byte_q;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
         up_q <= LO;
         pk_q <= EMPTY;
         byte_q <= '0;
         ov_q <= 1'b0;
         live_q <= 1'b0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         cnt_q <= cnt_d;
         up_q <= up_d;
         pk_q <= pk_d;
         byte_q <= byte_d;
         ov_q <= ov_d;
         live_q <= live_d;
      end
   end
   always_ff @(posedge clock) begin
      if (wr) mem[wp_q] <= rx_byte;
   end
endmodule

// File: tb/tb_uart_nibble_bridge.sv
// tb_uart_nibble_bridge: directed checks of the nibble bridge with DEPTH=4.
module tb_uart_nibble_bridge;
   logic clock = 1'b0;
   logic reset_n, rx_valid, overrun, nib_out_valid, nib_out_ready;
   logic nib_in_valid, nib_in_ready, tx_valid, tx_ready;
   logic [7:0] rx_byte, tx_byte;
   logic [3:0] nib_out, nib_in;
   int n_cmp = 0;
   int n_err = 0;
   logic [3:0] exp_q[$];
   logic [3:0] drain [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};
   logic [3:0] drain2 [6] = '{4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0};

   uart_nibble_bridge #(.DEPTH(4)) dut (
      .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .overrun(overrun), .nib_out_valid(nib_out_valid), .nib_out(nib_out),
      .nib_out_ready(nib_out_ready), .nib_in_valid(nib_in_valid), .nib_in(nib_in),
      .nib_in_ready(nib_in_ready), .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_ov"}, {7'd0, overrun}, 8'h00);
      chk({tag, "_nov"}, {7'd0, nib_out_valid}, 8'h00);
      chk({tag, "_no"}, {4'd0, nib_out}, 8'h00);
      chk({tag, "_nir"}, {7'd0, nib_in_ready}, 8'h00);
      chk({tag, "_txv"}, {7'd0, tx_valid}, 8'h00);
      chk({tag, "_txb"}, tx_byte, 8'h00);
   endtask

   initial begin
      int cnt, sent, got;
      logic ph, rv, rr;
      reset_n = 1'b0; rx_valid = 0; rx_byte = 0; nib_out_ready = 0;
      nib_in_valid = 0; nib_in = 0; tx_ready = 0;
      #1;
      all_zero("reset");
      tick(); tick();
      all_zero("reset_hold");
      #3 reset_n = 1'b1;
      tick();
      chk("nir_after_release", {7'd0, nib_in_ready}, 8'h01);
      chk("nov_after_release", {7'd0, nib_out_valid}, 8'h00);

      // RX basic
      rx_valid = 1; rx_byte = 8'hA5; nib_out_ready = 1;
      tick();
      rx_valid = 0;
      chk("basic_valid", {7'd0, nib_out_valid}, 8'h01);
      chk("basic_lo", {4'd0, nib_out}, 8'h05);
      tick();
      chk("basic_hi", {4'd0, nib_out}, 8'h0A);
      tick();
      chk("basic_empty", {7'd0, nib_out_valid}, 8'h00);

      // RX overrun
      nib_out_ready = 0;
      for (int i = 1; i <= 4; i++) begin
         rx_valid = 1; rx_byte = 8'(i * 8'h11);
         tick();
         chk("ovr_no_pulse", {7'd0, overrun}, 8'h00);
      end
      rx_byte = 8'h55;
      tick();
      rx_valid = 0;
      chk("ovr_pulse", {7'd0, overrun}, 8'h01);
      tick();
      chk("ovr_pulse_end", {7'd0, overrun}, 8'h00);
      nib_out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         chk("ovr_drain", {4'd0, nib_out}, {4'd0, drain[i]});
         tick();
      end
      chk("ovr_drained", {7'd0, nib_out_valid}, 8'h00);

      // Simultaneous drop with final HI pop of a full FIFO
      nib_out_ready = 0;
      for (int i = 1; i <= 4; i++) begin
         rx_valid = 1; rx_byte = 8'(i);
         tick();
      end
      rx_valid = 0;
      chk("sim_head_lo", {4'd0, nib_out}, 8'h01);
      nib_out_ready = 1;
      tick();
      chk("sim_head_hi", {4'd0, nib_out}, 8'h00);
      rx_valid = 1; rx_byte = 8'h99;
      tick();
      rx_valid = 0;
      chk("sim_overrun", {7'd0, overrun}, 8'h01);
      for (int i = 0; i < 6; i++) begin
         chk("sim_drain", {4'd0, nib_out}, {4'd0, drain2[i]});
         tick();
      end
      chk("sim_drained", {7'd0, nib_out_valid}, 8'h00);

      // RX backpressure, bench-side queue of expected nibbles
      cnt = 0; sent = 0; got = 0; ph = 0;
      for (int c = 0; c < 400 && got < 40; c++) begin
         rr = 1'($urandom_range(0, 1));
         rv = sent < 20 && cnt < 4 && $urandom_range(0, 1) == 1;
         nib_out_ready = rr; rx_valid = rv; rx_byte = 8'(8'h3C + 8'(sent * 7));
         chk("bp_valid", {7'd0, nib_out_valid}, {7'd0, cnt != 0});
         if (nib_out_valid && rr) begin
            chk("bp_nibble", {4'd0, nib_out}, {4'd0, exp_q.pop_front()});
            got++;
            if (ph) cnt--;
            ph = ~ph;
         end
         if (rv) begin
            exp_q.push_back(rx_byte[3:0]);
            exp_q.push_back(rx_byte[7:4]);
            cnt++; sent++;
         end
         tick();
         chk("bp_no_overrun", {7'd0, overrun}, 8'h00);
      end
      rx_valid = 0; nib_out_ready = 0;
      chk("bp_count", 8'(got), 8'd40);

      // TX pack
      nib_in_valid = 1; nib_in = 4'h3; tx_ready = 0;
      tick();
      chk("tx_have_lo_ready", {7'd0, nib_in_ready}, 8'h01);
      chk("tx_have_lo_valid", {7'd0, tx_valid}, 8'h00);
      nib_in = 4'hC;
      tick();
      nib_in = 4'h5;
      for (int i = 0; i < 3; i++) begin
         chk("tx_full_valid", {7'd0, tx_valid}, 8'h01);
         chk("tx_full_byte", tx_byte, 8'hC3);
         chk("tx_full_nir", {7'd0, nib_in_ready}, 8'h00);
         tick();
      end
      tx_ready = 1;
      nib_in_valid = 0;
      tick();
      tx_ready = 0;
      chk("tx_empty_valid", {7'd0, tx_valid}, 8'h00);
      chk("tx_empty_nir", {7'd0, nib_in_ready}, 8'h01);

      // Reset mid-stream: RX in HI, TX in HAVE_LO
      rx_valid = 1; rx_byte = 8'h5A; nib_in_valid = 1; nib_in = 4'h9;
      tick();
      rx_valid = 0; nib_in_valid = 0; nib_out_ready = 1;
      tick();
      nib_out_ready = 0;
      chk("mid_hi", {4'd0, nib_out}, 8'h05);
      #2 reset_n = 1'b0;
      #1;
      all_zero("mid_reset");
      tick();
      #3 reset_n = 1'b1;
      tick();
      chk("mid_nir", {7'd0, nib_in_ready}, 8'h01);
      chk("mid_nov", {7'd0, nib_out_valid}, 8'h00);
      rx_valid = 1; rx_byte = 8'h7E; nib_out_ready = 1; nib_in_valid = 1; nib_in = 4'hE;
      tick();
      rx_valid = 0; nib_in = 4'h7;
      chk("mid_rx_lo", {4'd0, nib_out}, 8'h0E);
      chk("mid_tx_partial", {7'd0, tx_valid}, 8'h00);
      tick();
      nib_in_valid = 0;
      chk("mid_rx_hi", {4'd0, nib_out}, 8'h07);
      chk("mid_tx_valid", {7'd0, tx_valid}, 8'h01);
      chk("mid_tx_byte", tx_byte, 8'h7E);
      tick();
      chk("mid_rx_empty", {7'd0, nib_out_valid}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
